// File: rtl/test_scheduler.sv
// Speed-test sequencer: clear stats, run generators for N ms, drain receivers, report.
// Optional TEST_SCHED_CYCLE_COUNT_EN adds a 64-bit run_cycles output.
module test_scheduler #(
    parameter int NUM_PORTS   = 4,
    parameter int CLK_FREQ_HZ = 125000000,
    parameter int WAIT_MS     = 100
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [12:0]          cfg_duration,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    input  logic [NUM_PORTS-1:0] port_enable,
    output logic                 busy,
    output logic [12:0]          actual_duration,
    output logic                 stat_clear,
    output logic                 stat_count_en,
    output logic [NUM_PORTS-1:0] gen_enable,
    output logic                 done
`ifdef TEST_SCHED_CYCLE_COUNT_EN
    ,output logic [63:0]         run_cycles
`endif
);

    localparam int TPM = CLK_FREQ_HZ / 1000;
    localparam int TW  = $clog2(TPM);
    localparam logic [TW-1:0] TICK_MAX  = TW'(TPM - 1);
    localparam logic [12:0]   WAIT_LAST = 13'(WAIT_MS - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [TW-1:0]          tick_cnt;
    logic [12:0]            ms_cnt;
    logic [12:0]            ms_next;
    logic [12:0]            dur_q;
    logic [NUM_PORTS-1:0]   pe_q;
    logic                   ms_tick;

    assign ms_tick = (tick_cnt == TICK_MAX);
    // ms counter saturates so an 8191 ms test cannot wrap back to zero
    assign ms_next = (ms_cnt == 13'h1fff) ? ms_cnt : ms_cnt + 13'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            tick_cnt        <= '0;
            ms_cnt          <= '0;
            dur_q           <= '0;
            pe_q            <= '0;
            busy            <= 1'b0;
            actual_duration <= '0;
            stat_clear      <= 1'b0;
            stat_count_en   <= 1'b0;
            gen_enable      <= '0;
            done            <= 1'b0;
`ifdef TEST_SCHED_CYCLE_COUNT_EN
            run_cycles      <= '0;
`endif
        end else begin
            stat_clear <= 1'b0;
            done       <= 1'b0;
            if (state == RUN || state == DRAIN) begin
                if (ms_tick) begin
                    tick_cnt <= '0;
                    ms_cnt   <= ms_next;
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
            end else begin
                tick_cnt <= '0;
                ms_cnt   <= '0;
            end

            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        dur_q      <= cfg_duration;
                        pe_q       <= port_enable;
                        busy       <= 1'b1;
                        stat_clear <= 1'b1;
                        state      <= CLEAR;
                    end
                end
                CLEAR: begin
`ifdef TEST_SCHED_CYCLE_COUNT_EN
                    run_cycles <= '0;
`endif
                    stat_count_en <= 1'b1;
                    if (dur_q == 13'd0) begin
                        actual_duration <= '0;
                        state           <= DRAIN;
                    end else begin
                        gen_enable <= pe_q;
                        state      <= RUN;
                    end
                end
                RUN: begin
`ifdef TEST_SCHED_CYCLE_COUNT_EN
                    run_cycles <= run_cycles + 64'd1;
`endif
                    if (ms_tick && ms_next == dur_q) begin
                        actual_duration <= dur_q;
                        gen_enable      <= '0;
                        tick_cnt        <= '0;
                        ms_cnt          <= '0;
                        state           <= DRAIN;
                    end else if (cfg_abort) begin
                        // a millisecond finishing on the abort edge still counts as completed
                        actual_duration <= ms_tick ? ms_next : ms_cnt;
                        gen_enable      <= '0;
                        tick_cnt        <= '0;
                        ms_cnt          <= '0;
                        state           <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ms_tick && ms_cnt == WAIT_LAST) begin
                        stat_count_en <= 1'b0;
                        done          <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
